// File: rtl/lock_pkg.sv
// Shared types and constants for the password-lock sequencer and its entry buffer.
package lock_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetEntry,
    StLocked,
    StCheckEntry,
    StOpen,
    StAlarm
  } lock_state_e;

  localparam int unsigned NDIGITS = 3;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BUF_W   = NDIGITS * DIGIT_W;
  localparam int unsigned CNT_W   = 29;

  localparam logic [NDIGITS-1:0] ALL_BLANK = 3'b111;
  localparam logic [NDIGITS-1:0] FULL      = 3'b000;

  function automatic logic digit_ok(logic [DIGIT_W-1:0] code);
    return code <= DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/digit_entry_buf.sv
// Shift buffer for digit entry: newest digit lands in the low nibble, mask tracks blank slots.
module digit_entry_buf
  import lock_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               key_i,
  input  logic [DIGIT_W-1:0] code_i,
  output logic               accept_o,
  output logic               full_o,
  output logic [BUF_W-1:0]   digits_o,
  output logic [NDIGITS-1:0] mask_o
);

  logic [BUF_W-1:0]   digits_q, digits_d;
  logic [NDIGITS-1:0] mask_q, mask_d;

  // Acceptance ignores clear_i on purpose so the controller's next-state logic stays loop-free.
  assign accept_o = key_i && digit_ok(code_i) && (mask_q != FULL);
  assign full_o   = (mask_q == FULL);
  assign digits_o = digits_q;
  assign mask_o   = mask_q;

  always_comb begin
    digits_d = digits_q;
    mask_d   = mask_q;
    if (clear_i) begin
      digits_d = '0;
      mask_d   = ALL_BLANK;
    end else if (accept_o) begin
      digits_d = {digits_q[BUF_W-DIGIT_W-1:0], code_i};
      mask_d   = {mask_q[NDIGITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      digits_q <= '0;
      mask_q   <= ALL_BLANK;
    end else begin
      digits_q <= digits_d;
      mask_q   <= mask_d;
    end
  end

endmodule

// File: rtl/lock_seq_ctrl.sv
// Password-lock sequencer: set/lock/check/open/alarm flow, stored password, wrong-try count,
// and the display-facing mode, digit and blank-mask outputs.
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned OPEN_CYCLES  = 100_000_000,
  parameter int unsigned IDLE_TIMEOUT = 500_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_vld,
  input  logic [3:0]   key_code,
  input  logic         set_btn,
  input  logic         check_btn,
  input  logic         confirm_btn,
  input  logic         clr_btn,
  output logic         set,
  output logic         check,
  output logic         confirm,
  output logic         boom,
  output logic [11:0]  setnum,
  output logic [11:0]  checknum,
  output logic [2:0]   seat,
  output logic [2:0]   seatc,
  output logic         unlocked,
  output logic [1:0]   err_cnt
);

  localparam logic [CNT_W-1:0] OpenLast = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [1:0]       MaxErr   = 2'(MAX_TRIES);

  lock_state_e        state_q, state_d;
  logic [BUF_W-1:0]   pw_q, pw_d;
  logic               has_pw_q, has_pw_d;
  logic [1:0]         err_q, err_d, err_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               confirm_d;
  logic               set_q, check_q, confirm_q, boom_q, unlocked_q;

  logic               clr_req, activity, entry_key, entered_entry, entry_clear;
  logic               key_acc, entry_full;
  logic [BUF_W-1:0]   entry_digits;
  logic [NDIGITS-1:0] entry_mask;

  digit_entry_buf u_entry (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (entry_clear),
    .key_i    (entry_key),
    .code_i   (key_code),
    .accept_o (key_acc),
    .full_o   (entry_full),
    .digits_o (entry_digits),
    .mask_o   (entry_mask)
  );

  // Per-cycle priority inside entry states: clr > confirm > key; set/check are dropped there.
  always_comb begin
    state_d   = state_q;
    pw_d      = pw_q;
    has_pw_d  = has_pw_q;
    err_d     = err_q;
    confirm_d = 1'b0;
    clr_req   = 1'b0;
    activity  = 1'b0;
    entry_key = 1'b0;
    err_inc   = err_q + 2'd1;
    unique case (state_q)
      StIdle:   if (set_btn) state_d = StSetEntry;
      StLocked: if (check_btn) state_d = StCheckEntry;
      StOpen: begin
        if (set_btn) state_d = StSetEntry;
        else if (cnt_q == OpenLast) state_d = StLocked;
      end
      StSetEntry, StCheckEntry: begin
        if (clr_btn) begin
          clr_req  = 1'b1;
          activity = 1'b1;
        end else if (confirm_btn) begin
          activity = 1'b1;
          if (entry_full) begin
            if (state_q == StSetEntry) begin
              pw_d      = entry_digits;
              has_pw_d  = 1'b1;
              err_d     = '0;
              confirm_d = 1'b1;
              state_d   = StLocked;
            end else if (entry_digits == pw_q) begin
              err_d     = '0;
              confirm_d = 1'b1;
              state_d   = StOpen;
            end else begin
              err_d   = err_inc;
              state_d = (err_inc == MaxErr) ? StAlarm : StLocked;
            end
          end
        end else if (key_vld) begin
          entry_key = 1'b1;
        end
        if (!activity && !key_acc && (cnt_q == IdleLast)) begin
          state_d = (state_q == StSetEntry && !has_pw_q) ? StIdle : StLocked;
        end
      end
      StAlarm: ;
      default: state_d = StIdle;
    endcase
  end

  assign entered_entry = (state_d != state_q) &&
                         ((state_d == StSetEntry) || (state_d == StCheckEntry));
  assign entry_clear   = clr_req || entered_entry;

  // One counter serves both the OPEN dwell and the entry inactivity timer; it saturates.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || activity || key_acc) cnt_d = '0;
    else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      pw_q       <= '0;
      has_pw_q   <= 1'b0;
      err_q      <= '0;
      cnt_q      <= '0;
      set_q      <= 1'b0;
      check_q    <= 1'b0;
      confirm_q  <= 1'b0;
      boom_q     <= 1'b0;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_q       <= pw_d;
      has_pw_q   <= has_pw_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      set_q      <= (state_d == StSetEntry);
      check_q    <= (state_d == StCheckEntry);
      confirm_q  <= confirm_d;
      boom_q     <= (state_d == StAlarm);
      unlocked_q <= (state_d == StOpen);
    end
  end

  assign set      = set_q;
  assign check    = check_q;
  assign confirm  = confirm_q;
  assign boom     = boom_q;
  assign unlocked = unlocked_q;
  assign err_cnt  = err_q;
  assign setnum   = set_q ? entry_digits : '0;
  assign seat     = set_q ? entry_mask : ALL_BLANK;
  assign checknum = check_q ? entry_digits : '0;
  assign seatc    = check_q ? entry_mask : ALL_BLANK;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Bench for lock_seq_ctrl: directed flows with literal expectations, then random pulses,
// all cross-checked every cycle against a digit-queue model of the lock.
module tb_lock_seq_ctrl;

  localparam int MT = 3;
  localparam int OC = 20;
  localparam int IT = 30;

  localparam int M_IDLE = 0, M_SET = 1, M_LOCKED = 2, M_CHECK = 3, M_OPEN = 4, M_ALARM = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_vld = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        set_btn = 1'b0, check_btn = 1'b0, confirm_btn = 1'b0, clr_btn = 1'b0;
  logic        set, check, confirm, boom, unlocked;
  logic [11:0] setnum, checknum;
  logic [2:0]  seat, seatc;
  logic [1:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lock_seq_ctrl #(
    .MAX_TRIES    (MT),
    .OPEN_CYCLES  (OC),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_vld     (key_vld),
    .key_code    (key_code),
    .set_btn     (set_btn),
    .check_btn   (check_btn),
    .confirm_btn (confirm_btn),
    .clr_btn     (clr_btn),
    .set         (set),
    .check       (check),
    .confirm     (confirm),
    .boom        (boom),
    .setnum      (setnum),
    .checknum    (checknum),
    .seat        (seat),
    .seatc       (seatc),
    .unlocked    (unlocked),
    .err_cnt     (err_cnt)
  );

  // Model: mode number, queue of entered digits, stored password value, timer.
  int m_mode = M_IDLE;
  int q[$];
  int pw = 0;
  bit has_pw = 0;
  int err = 0;
  int timer = 0;
  bit m_conf = 0;
  bit m_valid = 0;

  function automatic int pack_digits();
    int v = 0;
    foreach (q[i]) v = (v * 16) + q[i];
    return v;
  endfunction

  function automatic int blank_mask(int n);
    return (7 * (1 << n)) % 8;
  endfunction

  function automatic void enter(int m);
    m_mode = m;
    timer  = 0;
    if (m == M_SET || m == M_CHECK) q.delete();
  endfunction

  function automatic void commit();
    int v = pack_digits();
    if (m_mode == M_SET) begin
      pw = v; has_pw = 1; err = 0; m_conf = 1;
      enter(M_LOCKED);
    end else if (v == pw) begin
      err = 0; m_conf = 1;
      enter(M_OPEN);
    end else begin
      err = err + 1;
      enter(err == MT ? M_ALARM : M_LOCKED);
    end
  endfunction

  always @(posedge clk) begin
    m_conf = 0;
    if (!rst) begin
      m_mode = M_IDLE; q.delete(); pw = 0; has_pw = 0; err = 0; timer = 0;
    end else begin
      case (m_mode)
        M_IDLE:   if (set_btn) enter(M_SET);
        M_LOCKED: if (check_btn) enter(M_CHECK);
        M_OPEN: begin
          if (set_btn) enter(M_SET);
          else if (timer == OC - 1) enter(M_LOCKED);
          else timer++;
        end
        M_SET, M_CHECK: begin
          if (clr_btn) begin
            q.delete(); timer = 0;
          end else if (confirm_btn) begin
            timer = 0;
            if (q.size() == 3) commit();
          end else if (key_vld && key_code <= 9 && q.size() < 3) begin
            q.push_back(int'(key_code)); timer = 0;
          end else if (timer == IT - 1) begin
            enter((m_mode == M_SET && !has_pw) ? M_IDLE : M_LOCKED);
          end else begin
            timer++;
          end
        end
        default: ;
      endcase
    end
    m_valid = 1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [36:0] exp_v, got_v;
    if (m_valid) begin
      exp_v = {m_mode == M_SET, m_mode == M_CHECK, m_conf, m_mode == M_ALARM,
               12'(m_mode == M_SET ? pack_digits() : 0),
               12'(m_mode == M_CHECK ? pack_digits() : 0),
               3'(m_mode == M_SET ? blank_mask(q.size()) : 7),
               3'(m_mode == M_CHECK ? blank_mask(q.size()) : 7),
               m_mode == M_OPEN, 2'(err)};
      got_v = {set, check, confirm, boom, setnum, checknum, seat, seatc, unlocked, err_cnt};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model_compare t=%0t got=%h required=%h", $time, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic drive(input bit k, input int code, input bit s, input bit c, input bit cf,
                       input bit cl);
    @(negedge clk);
    key_vld = k; key_code = 4'(code); set_btn = s; check_btn = c;
    confirm_btn = cf; clr_btn = cl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic key(input int code);
    drive(1, code, 0, 0, 0, 0);
  endtask

  task automatic keys3(input int a, input int b, input int c);
    key(a); key(b); key(c);
  endtask

  task automatic wrong_check();
    drive(0, 0, 0, 1, 0, 0);
    keys3(4, 5, 6);
    drive(0, 0, 0, 0, 1, 0);
    idle();
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) idle();
    chk("reset_set", 32'(set), 0);
    chk("reset_seat", 32'(seat), 7);
    chk("reset_seatc", 32'(seatc), 7);
    chk("reset_err", 32'(err_cnt), 0);
    @(negedge clk) rst = 1'b1;

    // Set flow
    drive(0, 0, 1, 0, 0, 0);
    keys3(1, 2, 3);
    idle();
    chk("set_setnum", 32'(setnum), 32'h123);
    chk("set_seat", 32'(seat), 0);
    drive(0, 0, 0, 0, 1, 0);
    idle();
    chk("set_confirm_pulse", 32'(confirm), 1);
    chk("set_left_entry", 32'(set), 0);
    idle();
    chk("set_confirm_one_cycle", 32'(confirm), 0);

    // Good check and OPEN dwell
    drive(0, 0, 0, 1, 0, 0);
    keys3(1, 2, 3);
    drive(0, 0, 0, 0, 1, 0);
    idle();
    chk("open_confirm", 32'(confirm), 1);
    chk("open_unlocked", 32'(unlocked), 1);
    repeat (OC - 1) idle();
    chk("open_last_cycle", 32'(unlocked), 1);
    idle();
    chk("open_relocked", 32'(unlocked), 0);

    // Entry edge cases
    drive(0, 0, 0, 1, 0, 0);
    key(1); key(2);
    drive(0, 0, 0, 0, 1, 0);
    idle();
    chk("short_confirm_ignored", 32'(check), 1);
    chk("two_digits", 32'(checknum), 32'h012);
    chk("two_digit_mask", 32'(seatc), 32'b100);
    key(3); key(4);
    idle();
    chk("fourth_key_ignored", 32'(checknum), 32'h123);
    drive(0, 0, 0, 0, 0, 1);
    idle();
    chk("clr_mask", 32'(seatc), 7);
    key(4'hC);
    idle();
    chk("bad_code_ignored", 32'(seatc), 7);
    key(5);
    drive(1, 7, 0, 0, 0, 1);
    idle();
    chk("clr_beats_key", 32'(checknum), 0);
    drive(0, 0, 0, 0, 0, 1);
    idle();

    // Wrong checks, timeout, alarm
    chk("still_checking", 32'(check), 1);
    keys3(4, 5, 6);
    drive(0, 0, 0, 0, 1, 0);
    idle();
    chk("err_one", 32'(err_cnt), 1);
    drive(0, 0, 0, 1, 0, 0);
    idle();
    repeat (IT - 1) idle();
    chk("before_timeout", 32'(check), 1);
    idle();
    chk("timeout_exit", 32'(check), 0);
    chk("timeout_err_kept", 32'(err_cnt), 1);
    wrong_check();
    chk("err_two", 32'(err_cnt), 2);
    chk("no_boom_yet", 32'(boom), 0);
    wrong_check();
    chk("boom", 32'(boom), 1);
    drive(0, 0, 1, 1, 0, 0);
    keys3(1, 2, 3);
    drive(0, 0, 0, 0, 1, 1);
    idle();
    chk("boom_sticky", 32'(boom), 1);
    @(negedge clk) rst = 1'b0;
    idle();
    chk("reset_clears_boom", 32'(boom), 0);
    chk("reset_clears_err", 32'(err_cnt), 0);
    @(negedge clk) rst = 1'b1;

    // Reset mid check entry
    drive(0, 0, 1, 0, 0, 0);
    keys3(7, 8, 9);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    key(7);
    idle();
    chk("mid_check_digit", 32'(checknum), 7);
    @(negedge clk) rst = 1'b0;
    idle();
    chk("rst_mid_check", 32'(check), 0);
    chk("rst_mid_checknum", 32'(checknum), 0);
    chk("rst_mid_seatc", 32'(seatc), 7);
    @(negedge clk) rst = 1'b1;

    // Random pulses against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      key_vld     = ($urandom_range(0, 99) < 35);
      key_code    = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 3))
                                               : 4'($urandom_range(0, 15));
      set_btn     = ($urandom_range(0, 99) < 6);
      check_btn   = ($urandom_range(0, 99) < 8);
      confirm_btn = ($urandom_range(0, 99) < 12);
      clr_btn     = ($urandom_range(0, 99) < 4);
      rst         = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        repeat (45) idle();
      end
    end
    @(negedge clk) rst = 1'b1;
    repeat (2) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_seq_ctrl.md
# lock_seq_ctrl

Sequencer for the password lock. It takes debounced one-cycle key and button pulses and runs the set, lock, check, open and alarm flow. It holds the stored 3-digit password and the wrong-attempt count. It also drives the mode, digit and blank-mask signals that the seven-segment display controller consumes (set, confirm, check, boom, setnum, checknum, seat, seatc).

## Interface
- MAX_TRIES, 3: wrong checks that trigger the alarm (1..3).
- OPEN_CYCLES, 100_000_000: cycles the lock stays OPEN before relocking automatically.
- IDLE_TIMEOUT, 500_000_000: inactivity cycles during digit entry before the entry is aborted.
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  reset. Synchronous, active-low.
- key_vld  in  1  one-cycle pulse: a digit key was pressed.
- key_code  in  4  digit value (0..9). Valid when key_vld is high; values above 9 are ignored.
- set_btn  in  1  one-cycle pulse: enter password-set mode.
- check_btn  in  1  one-cycle pulse: enter check (unlock) mode.
- confirm_btn  in  1  one-cycle pulse: commit the current entry.
- clr_btn  in  1  one-cycle pulse: clear the current entry.
- set  out  1  level, high in SET_ENTRY.
- check  out  1  level, high in CHECK_ENTRY.
- confirm  out  1  one-cycle pulse on a successful set commit or a matching check.
- boom  out  1  level, high in ALARM.
- setnum  out  12  digits being entered in SET_ENTRY, newest digit in [3:0].
- checknum  out  12  digits being entered in CHECK_ENTRY, newest digit in [3:0].
- seat  out  3  blank mask for setnum. Bit i = 1 means digit i is not yet entered.
- seatc  out  3  blank mask for checknum, same encoding as seat.
- unlocked  out  1  level, high in OPEN.
- err_cnt  out  2  wrong attempts since the last successful check.

## Operation
- States: IDLE (no password stored), SET_ENTRY, LOCKED, CHECK_ENTRY, OPEN, ALARM.
- IDLE:
  - set_btn → SET_ENTRY.
  - All other inputs are ignored.
- LOCKED:
  - check_btn → CHECK_ENTRY.
  - set_btn is ignored.
- OPEN:
  - set_btn → SET_ENTRY.
  - check_btn is ignored.
  - After OPEN_CYCLES the state returns to LOCKED.
- On entering SET_ENTRY or CHECK_ENTRY:
  - The entry buffer is cleared to 0.
  - The mask is set to 3'b111.
  - The inactivity counter is cleared.
- Accepted key (key_vld with key_code ≤ 9, mask ≠ 0):
  - buffer ← {buffer[7:0], key_code}.
  - mask ← {mask[1:0], 1'b0}.
  - Mask sequence: 111 → 110 → 100 → 000.
- A key arriving when the mask is 000 is ignored (buffer full).
- clr_btn: buffer ← 0, mask ← 111. The state is unchanged.
- confirm_btn when mask ≠ 000 is ignored.
- confirm_btn in SET_ENTRY with mask = 000:
  - The password register takes the buffer.
  - err_cnt ← 0.
  - confirm pulses.
  - Next state is LOCKED.
- confirm_btn in CHECK_ENTRY with mask = 000 and buffer equal to the password:
  - err_cnt ← 0.
  - confirm pulses.
  - Next state is OPEN.
- confirm_btn in CHECK_ENTRY with mask = 000 and a mismatch:
  - err_cnt increments.
  - If the new count equals MAX_TRIES, next state is ALARM; otherwise LOCKED.
- Inactivity timeout (IDLE_TIMEOUT cycles without an accepted key, clr or confirm):
  - SET_ENTRY returns to LOCKED if a password is stored, otherwise to IDLE.
  - CHECK_ENTRY returns to LOCKED. err_cnt is unchanged.
- ALARM is terminal until reset. boom stays high and every input is ignored.
- Simultaneous inputs, priority per cycle: clr_btn > confirm_btn > key_vld > set_btn/check_btn. Lower-priority pulses in that cycle are dropped.
- Outside the matching entry state, setnum/seat and checknum/seatc read 0 and 3'b111.

## Timing
- All outputs are registered. Each takes effect on the first rising edge after the qualifying input pulse, so latency is 1 cycle.
- confirm is high for exactly one cycle, coincident with the first cycle of LOCKED or OPEN.
- Reset values:
  - State is IDLE. The password register and both buffers are 0.
  - seat and seatc are 3'b111.
  - set, check, confirm, boom, unlocked are 0. err_cnt is 0.
  - All counters are 0.
- Asserting reset mid-entry or during ALARM returns every register to the reset values on the next edge.
- OPEN counter: OPEN is exited on the edge after the counter reaches OPEN_CYCLES−1. A set_btn in that same cycle wins.
- Counters are 29 bits. Each clears on state entry and saturates, so it never wraps.

## Structure
- A shared package, lock_pkg, holds:
  - the state enumeration;
  - NDIGITS = 3 and DIGIT_W = 4;
  - the mask encodings (ALL_BLANK = 3'b111, FULL = 3'b000).
- One natural sub-module: digit_entry_buf, covering shift, mask, clear and full detection. It is instantiated once and muxed into the set/check outputs by state.

## Test plan
- Set flow: reset, set_btn, keys 1,2,3, confirm_btn.
  - Before confirm: setnum = 12'h123, seat = 000.
  - After confirm: one-cycle confirm, state LOCKED.
- Good check: with the password at 123, check_btn then keys 1,2,3 then confirm_btn → confirm pulse, unlocked = 1. unlocked clears after OPEN_CYCLES (use a reduced parameter).
- Three wrong checks (keys 4,5,6 each time):
  - err_cnt goes 1, then 2.
  - boom goes high after the third confirm and stays high through further inputs until reset.
- Entry edge cases:
  - Confirm with 2 digits is ignored.
  - A 4th key is ignored (checknum unchanged).
  - clr_btn restores seatc = 111.
  - key_code = 4'hC is ignored.
- Simultaneous pulses: clr_btn and key_vld in the same cycle → the buffer clears and the key is dropped.
- Reset and timeout:
  - Reset asserted mid-CHECK_ENTRY → all reset values on the next edge.
  - Entry left idle for IDLE_TIMEOUT (reduced parameter) → back to LOCKED with err_cnt unchanged.
